instr_encoder: RTL

Sequential MIPS instruction encoder, the write-side counterpart of the control decoder. Accepts a stream of decoded instruction descriptors (mnemonic code plus register, immediate and target fields) over a valid/ready handshake. Packs each descriptor into a 32-bit MIPS word and writes it into instruction memory at consecutive word addresses. Used by the bench/boot path to load programs for the single-cycle CPU, covering exactly the 21 instructions that CPU decodes.

---
 rtl/mips_isa_pkg.sv | 57 +++++
 rtl/instr_pack.sv | 49 ++++
 rtl/instr_encoder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the instruction encoder and the control decoder.
package mips_isa_pkg;

  // Field widths of the 32-bit instruction word.
  localparam int unsigned OpW    = 6;
  localparam int unsigned RegW   = 5;
  localparam int unsigned ImmW   = 16;
  localparam int unsigned TgtW   = 26;
  localparam int unsigned MnemW  = 5;

  // Mnemonic codes; anything above MnBne is illegal.
  typedef enum logic [MnemW-1:0] {
    MnAdd, MnSub, MnAnd, MnOr, MnSlt, MnSltu, MnAddu, MnSubu, MnSll, MnNor,
    MnAddi, MnOri, MnLw, MnSw, MnBeq, MnLui, MnSlti, MnAndi, MnJ, MnJal, MnBne
  } mnem_e;

  localparam logic [OpW-1:0] OpRtype = 6'h00;
  localparam logic [OpW-1:0] OpAddi  = 6'h08;
  localparam logic [OpW-1:0] OpOri   = 6'h0D;
  localparam logic [OpW-1:0] OpLw    = 6'h23;
  localparam logic [OpW-1:0] OpSw    = 6'h2B;
  localparam logic [OpW-1:0] OpBeq   = 6'h04;
  localparam logic [OpW-1:0] OpLui   = 6'h0F;
  localparam logic [OpW-1:0] OpSlti  = 6'h0A;
  localparam logic [OpW-1:0] OpAndi  = 6'h0C;
  localparam logic [OpW-1:0] OpBne   = 6'h05;
  localparam logic [OpW-1:0] OpJ     = 6'h02;
  localparam logic [OpW-1:0] OpJal   = 6'h03;

  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnSltu = 6'h2B;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnNor  = 6'h27;

  function automatic logic [31:0] r_word(input logic [RegW-1:0] rs, input logic [RegW-1:0] rt,
                                         input logic [RegW-1:0] rd, input logic [RegW-1:0] shamt,
                                         input logic [5:0] funct);
    return {OpRtype, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [OpW-1:0] op, input logic [RegW-1:0] rs,
                                         input logic [RegW-1:0] rt, input logic [ImmW-1:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [OpW-1:0] op,
                                         input logic [TgtW-1:0] target);
    return {op, target};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: mnemonic plus fields to a 32-bit MIPS word.
module instr_pack
  import mips_isa_pkg::*;
(
  input  logic [MnemW-1:0] mnem,
  input  logic [RegW-1:0]  rs,
  input  logic [RegW-1:0]  rt,
  input  logic [RegW-1:0]  rd,
  input  logic [RegW-1:0]  shamt,
  input  logic [ImmW-1:0]  imm,
  input  logic [TgtW-1:0]  target,
  output logic [31:0]      word,
  output logic             illegal
);

  mnem_e m;
  assign m = mnem_e'(mnem);

  // Select the encoding; sll drops rs, other R-types drop shamt, lui drops rs.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (m)
      MnAdd:  word = r_word(rs, rt, rd, 5'd0, FnAdd);
      MnSub:  word = r_word(rs, rt, rd, 5'd0, FnSub);
      MnAnd:  word = r_word(rs, rt, rd, 5'd0, FnAnd);
      MnOr:   word = r_word(rs, rt, rd, 5'd0, FnOr);
      MnSlt:  word = r_word(rs, rt, rd, 5'd0, FnSlt);
      MnSltu: word = r_word(rs, rt, rd, 5'd0, FnSltu);
      MnAddu: word = r_word(rs, rt, rd, 5'd0, FnAddu);
      MnSubu: word = r_word(rs, rt, rd, 5'd0, FnSubu);
      MnSll:  word = r_word(5'd0, rt, rd, shamt, FnSll);
      MnNor:  word = r_word(rs, rt, rd, 5'd0, FnNor);
      MnAddi: word = i_word(OpAddi, rs, rt, imm);
      MnOri:  word = i_word(OpOri, rs, rt, imm);
      MnLw:   word = i_word(OpLw, rs, rt, imm);
      MnSw:   word = i_word(OpSw, rs, rt, imm);
      MnBeq:  word = i_word(OpBeq, rs, rt, imm);
      MnLui:  word = i_word(OpLui, 5'd0, rt, imm);
      MnSlti: word = i_word(OpSlti, rs, rt, imm);
      MnAndi: word = i_word(OpAndi, rs, rt, imm);
      MnJ:    word = j_word(OpJ, target);
      MnJal:  word = j_word(OpJal, target);
      MnBne:  word = i_word(OpBne, rs, rt, imm);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams instruction descriptors into instruction memory at consecutive addresses.
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int unsigned AW   = 8,
  parameter int unsigned BASE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [4:0]       in_mnem,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_shamt,
  input  logic [15:0]      in_imm,
  input  logic [25:0]      in_target,
  output logic             im_we,
  output logic [AW-1:0]    im_addr,
  output logic [31:0]      im_wdata,
  output logic [AW:0]      count,
  output logic             done,
  output logic [1:0]       err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StFin  = 2'd2;
  localparam logic [1:0] StHalt = 2'd3;

  localparam logic [AW-1:0] BaseAddr = AW'(BASE);
  localparam logic [AW-1:0] LastAddr = '1;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   count_q, count_d;
  logic          done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic [31:0] word;
  logic        illegal;
  logic        accept;

  instr_pack u_pack (
    .mnem    (in_mnem),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .shamt   (in_shamt),
    .imm     (in_imm),
    .target  (in_target),
    .word    (word),
    .illegal (illegal)
  );

  assign in_ready = (state_q == StLoad);
  // A start in the same cycle as a beat restarts the session and drops the beat.
  assign accept   = in_valid & in_ready & ~start;

  assign im_we    = we_q;
  assign im_addr  = waddr_q;
  assign im_wdata = wdata_q;
  assign count    = count_q;
  assign done     = done_q;
  assign err      = err_q;

  // Session sequencing, write staging and sticky status.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    done_d  = done_q;
    err_d   = err_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (start) begin
      state_d = StLoad;
      addr_d  = BaseAddr;
      count_d = '0;
      done_d  = 1'b0;
      err_d   = 2'b00;
    end else begin
      case (state_q)
        StLoad: begin
          if (accept) begin
            if (illegal) begin
              err_d[0] = 1'b1;
              state_d  = StHalt;
            end else begin
              we_d    = 1'b1;
              waddr_d = addr_q;
              wdata_d = word;
              count_d = count_q + (AW+1)'(1);
              if (in_last) begin
                state_d = StFin;
              end else if (addr_q == LastAddr) begin
                // Top word written but more beats pending: no room, stop.
                err_d[1] = 1'b1;
                state_d  = StHalt;
              end
              // The address register never wraps back to 0.
              if (addr_q != LastAddr) addr_d = addr_q + AW'(1);
            end
          end
        end
        StFin: begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: ;
      endcase
    end
  end

  // State and output registers; reset also kills any pending write strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= BaseAddr;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 2'b00;
      we_q    <= 1'b0;
      waddr_q <= BaseAddr;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule
